// File: rtl/bit_index_pkg.sv
// Shared mode codes and FSM state encoding for the bit index encoder.
// Pure declarations: no latency, no flow control.
package bit_index_pkg;

    localparam logic [1:0] MODE_STRICT = 2'b00;
    localparam logic [1:0] MODE_PRIO   = 2'b01;
    localparam logic [1:0] MODE_ENUM   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/lsb_finder.sv
// Lowest-set-bit index of a vector plus an any-bit-set flag.
// Purely combinational, so it has zero latency and no flow control.
module lsb_finder #(
    parameter int WIDTH  = 32,
    parameter int CODE_W = 5
) (
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              found
);

    // Scan downward so the lowest set bit is the last one to write idx.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign found = |vec;

endmodule

// File: rtl/bit_index_encoder.sv
// Turns a request word into a registered stream of set-bit indices (strict, priority or enumerate).
// Latency is 1 cycle from accept. Code, Last, Error and Count hold while OutReady is low, and no new word is taken until the last beat drains.
module bit_index_encoder #(
    parameter int WIDTH  = 32,
    parameter int CODE_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  Data,
    input  logic [1:0]        Mode,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CODE_W-1:0] Code,
    output logic              Last,
    output logic              Error,
    output logic [CODE_W:0]   Count
);

    import bit_index_pkg::*;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  work;
    logic [1:0]        mode_q;
    logic              err_q;
    logic [CODE_W:0]   count_q;

    logic [CODE_W:0]   pop;
    logic              err_acc;
    logic              accept;
    logic              beat_done;
    logic              last_beat;
    logic [CODE_W-1:0] lsb_idx;
    logic              lsb_found;

    lsb_finder #(
        .WIDTH  (WIDTH),
        .CODE_W (CODE_W)
    ) u_lsb_finder (
        .vec   (work),
        .idx   (lsb_idx),
        .found (lsb_found)
    );

    assign InReady   = (state == ST_IDLE) & ~Reset;
    assign accept    = InValid & InReady;
    assign OutValid  = (state == ST_EMIT);
    assign beat_done = OutValid & OutReady;

    // Enumerate ends when at most one bit remains; other modes always emit a single beat.
    assign last_beat = (mode_q != MODE_ENUM) | ~(|(work & (work - ONE)));

    assign Code  = lsb_found ? lsb_idx : '0;
    assign Last  = OutValid & last_beat;
    assign Error = err_q;
    assign Count = count_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{CODE_W{1'b0}}, Data[i]};
        end
    end

    always_comb begin
        err_acc = 1'b1;
        case (Mode)
            MODE_STRICT: err_acc = (pop != (CODE_W + 1)'(1));
            MODE_PRIO:   err_acc = (pop == '0);
            MODE_ENUM:   err_acc = (pop == '0);
            MODE_RSVD:   err_acc = 1'b1;
            default:     err_acc = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EMIT;
            ST_EMIT: if (beat_done && last_beat) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            work    <= '0;
            mode_q  <= MODE_STRICT;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work    <= Data;
                mode_q  <= Mode;
                err_q   <= err_acc;
                count_q <= pop;
            end else if (beat_done) begin
                // Clearing everything on the final beat keeps idle outputs at zero.
                if (last_beat) begin
                    work    <= '0;
                    err_q   <= 1'b0;
                    count_q <= '0;
                end else begin
                    work <= work & (work - ONE);
                end
            end
        end
    end

endmodule
